fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 153 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that reads bytes straight from a FIFO read port.
// Frames are LSB-first 8N1, or 8E1/8O1 when PARITY_EN=1. A byte can be accepted
// in the last STOP cycle, so a continuously non-empty FIFO produces frames with no gap.
//
// Handshake: a byte moves on a rising edge where s_valid=1 and s_ready=1.
// s_ready is combinational from the state only (never from s_valid), is high in IDLE
// and in the last STOP cycle, and is held low while rst_n=0. When s_valid=1 and
// s_ready=0 the byte is left in place for a later cycle.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [9:0] BAUD_LAST = 10'(CLKS_PER_BIT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_baud;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic       r_tx;
    logic       r_busy;
    logic       w_tx_next;
    logic       w_bit_end;
    logic       w_last_stop;
    logic       w_accept;
    logic       w_parity;
    logic [2:0] w_idx_next;

    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_last_stop = (r_state == ST_STOP) && w_bit_end;
    assign s_ready     = rst_n && ((r_state == ST_IDLE) || w_last_stop);
    assign w_accept    = s_valid && s_ready;
    // Captured byte is held unshifted, so parity can be taken from it directly.
    assign w_parity    = (^r_shift) ^ (PARITY_ODD != 0);
    assign w_idx_next  = r_bit_idx + 3'd1;

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign frame_done  = w_last_stop;
    assign o_dbg_state = r_state;

    // Next-state and next serial-line value, decided at each bit boundary.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = w_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_tx_next = r_shift[w_idx_next];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (w_accept) begin
                        w_state_next = ST_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: line driver, busy flag, baud counter, bit index and captured byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_baud    <= 10'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= (w_state_next != ST_IDLE);
            if ((r_state == ST_IDLE) || w_bit_end) begin
                r_baud <= 10'd0;
            end else begin
                r_baud <= r_baud + 10'd1;
            end
            // Index wraps 7 -> 0 on its own, ready for the next frame.
            if ((r_state == ST_DATA) && w_bit_end) begin
                r_bit_idx <= w_idx_next;
            end
            if (w_accept) begin
                r_shift <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLKS_PER_BIT=4: one 8N1 instance with a serial
// decoder and scoreboard, plus an even- and an odd-parity instance sharing inputs.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready, tx, busy, frame_done;
  logic [2:0] dbg0;

  logic [7:0] p_data;
  logic       p_valid;
  logic       p1_ready, p1_tx, p1_busy, p1_done;
  logic       p2_ready, p2_tx, p2_busy, p2_done;
  logic [2:0] dbg1, dbg2;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  bit mon_en = 1'b0;
  bit mon_busy = 1'b0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx(tx), .busy(busy), .frame_done(frame_done), .o_dbg_state(dbg0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(p_data), .s_valid(p_valid), .s_ready(p1_ready),
    .tx(p1_tx), .busy(p1_busy), .frame_done(p1_done), .o_dbg_state(dbg1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(p_data), .s_valid(p_valid), .s_ready(p2_ready),
    .tx(p2_tx), .busy(p2_busy), .frame_done(p2_done), .o_dbg_state(dbg2)
  );

  // Expected line level k cycles after the accepting edge (k = 1 is the first START cycle).
  function automatic logic exp_bit(input logic [7:0] b, input int k, input logic par_en,
                                   input logic par);
    int slot;
    slot = (k - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && par_en) return par;
    return 1'b1;
  endfunction

  // Serial decoder on dut0: samples mid-bit, checks the stop bit, pops the scoreboard.
  initial begin
    logic [7:0] rx;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        mon_busy = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          rx[b] = tx;
        end
        repeat (CPB) @(negedge clk);
        total++;
        if (tx !== 1'b1) begin
          bad++;
          $display("FAIL stop_bit: tx=%b required 1", tx);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL decode_extra: got %h with empty expected queue", rx);
        end else begin
          e = exp_q.pop_front();
          if (rx !== e) begin
            bad++;
            $display("FAIL decode_byte: got %h required %h", rx, e);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((mon_busy || exp_q.size() != 0 || busy !== 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL wait_quiet: timeout, queue=%0d busy=%b required empty/0", exp_q.size(), busy);
    end
  endtask

  // Push one byte through dut0 from idle and check every cycle of its frame.
  task automatic send_and_check_frame(input logic [7:0] b);
    logic [2:0] got, want;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: s_ready=%b required 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = b;
    exp_q.push_back(b);
    for (int k = 1; k <= 10 * CPB; k++) begin
      @(negedge clk);
      if (k == 1) begin
        s_valid = 1'b0;
        s_data  = ~b;
      end
      got  = {tx, busy, frame_done};
      want = {exp_bit(b, k, 1'b0, 1'b0), 1'b1, (k == 10 * CPB)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL frame_%h k=%0d: tx/busy/done=%b required %b", b, k, got, want);
      end
    end
    @(negedge clk);
    got  = {tx, busy, s_ready};
    total++;
    if (got !== 3'b101) begin
      bad++;
      $display("FAIL frame_end_%h: tx/busy/ready=%b required 101", b, got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h55; p_valid = 1'b1; p_data = 8'h55;
    repeat (3) @(negedge clk);
    total++;
    if ({tx, busy, frame_done, s_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_dut0: tx/busy/done/ready=%b required 1000", {tx, busy, frame_done, s_ready});
    end
    total++;
    if ({p1_tx, p1_busy, p1_ready, p2_tx, p2_busy, p2_ready} !== 6'b100100) begin
      bad++;
      $display("FAIL reset_parity: %b required 100100",
               {p1_tx, p1_busy, p1_ready, p2_tx, p2_busy, p2_ready});
    end
    s_valid = 1'b0; p_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if ({s_ready, p1_ready, p2_ready} !== 3'b111) begin
      bad++;
      $display("FAIL reset_release_ready: %b required 111", {s_ready, p1_ready, p2_ready});
    end
    @(negedge clk);
    total++;
    if ({tx, busy, s_ready} !== 3'b101) begin
      bad++;
      $display("FAIL after_reset: tx/busy/ready=%b required 101", {tx, busy, s_ready});
    end
  endtask

  task automatic test_single_frame();
    mon_en = 1'b1;
    send_and_check_frame(8'hA5);
    wait_quiet();
  endtask

  task automatic test_back_to_back();
    int hs;
    logic [7:0] b;
    logic [3:0] got, want;
    int kk;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h00;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    hs = (s_ready === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 20 * CPB; k++) begin
      @(negedge clk);
      if (k == 1) s_data = 8'hFF;
      if (k == 10 * CPB + 1) s_valid = 1'b0;
      kk = (k - 1) % (10 * CPB) + 1;
      b  = (k <= 10 * CPB) ? 8'h00 : 8'hFF;
      got  = {tx, busy, frame_done, s_ready};
      want = {exp_bit(b, kk, 1'b0, 1'b0), 1'b1, (kk == 10 * CPB), (kk == 10 * CPB)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL b2b k=%0d: tx/busy/done/ready=%b required %b", k, got, want);
      end
      if (s_valid && s_ready) hs++;
    end
    @(negedge clk);
    total++;
    if ({tx, busy} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_end: tx/busy=%b required 10", {tx, busy});
    end
    total++;
    if (hs != 2) begin
      bad++;
      $display("FAIL b2b_handshakes: %0d required 2", hs);
    end
    wait_quiet();
  endtask

  task automatic test_parity();
    logic [7:0] bytes_tbl [2];
    logic [7:0] b;
    logic [2:0] got1, want1, got2, want2;
    bytes_tbl[0] = 8'h07;
    bytes_tbl[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      b = bytes_tbl[i];
      @(negedge clk);
      total++;
      if ({p1_ready, p2_ready} !== 2'b11) begin
        bad++;
        $display("FAIL parity_idle_ready: %b required 11", {p1_ready, p2_ready});
      end
      p_valid = 1'b1;
      p_data  = b;
      for (int k = 1; k <= 11 * CPB; k++) begin
        @(negedge clk);
        if (k == 1) begin
          p_valid = 1'b0;
          p_data  = ~b;
        end
        got1  = {p1_tx, p1_busy, p1_done};
        want1 = {exp_bit(b, k, 1'b1, ^b), 1'b1, (k == 11 * CPB)};
        got2  = {p2_tx, p2_busy, p2_done};
        want2 = {exp_bit(b, k, 1'b1, ~(^b)), 1'b1, (k == 11 * CPB)};
        total++;
        if (got1 !== want1) begin
          bad++;
          $display("FAIL even_par_%h k=%0d: %b required %b", b, k, got1, want1);
        end
        total++;
        if (got2 !== want2) begin
          bad++;
          $display("FAIL odd_par_%h k=%0d: %b required %b", b, k, got2, want2);
        end
      end
      @(negedge clk);
      total++;
      if ({p1_tx, p1_busy, p2_tx, p2_busy} !== 4'b1010) begin
        bad++;
        $display("FAIL parity_end_%h: %b required 1010", b, {p1_tx, p1_busy, p2_tx, p2_busy});
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit fd_seen;
    mon_en = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    // Bit 3 occupies cycles 4*CPB+1 .. 5*CPB; reset is applied in the middle of it.
    for (int k = 1; k <= 4 * CPB + 2; k++) begin
      @(negedge clk);
      if (k == 1) s_valid = 1'b0;
    end
    total++;
    if (tx !== exp_bit(8'h5A, 4 * CPB + 2, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL mid_bit3: tx=%b required %b", tx, exp_bit(8'h5A, 4 * CPB + 2, 1'b0, 1'b0));
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({tx, busy, frame_done, s_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL mid_reset: tx/busy/done/ready=%b required 1000", {tx, busy, frame_done, s_ready});
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_release: s_ready=%b required 1", s_ready);
    end
    fd_seen = 1'b0;
    for (int k = 0; k < 12 * CPB; k++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) fd_seen = 1'b1;
    end
    total++;
    if (fd_seen) begin
      bad++;
      $display("FAIL aborted_frame: activity after reset=%b required 0", fd_seen);
    end
    mon_en = 1'b1;
    send_and_check_frame(8'h3C);
    wait_quiet();
  endtask

  task automatic test_random();
    int k_since, accepted, cycles;
    logic exp_r;
    k_since = 1000;
    accepted = 0;
    cycles = 0;
    while (accepted < 200 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      k_since++;
      exp_r = (k_since >= 10 * CPB);
      total++;
      if (s_ready !== exp_r) begin
        bad++;
        $display("FAIL rand_ready cyc=%0d: s_ready=%b required %b", cycles, s_ready, exp_r);
      end
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom_range(0, 255));
      if (s_valid && exp_r) begin
        exp_q.push_back(s_data);
        accepted++;
        k_since = 0;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    total++;
    if (accepted != 200) begin
      bad++;
      $display("FAIL rand_accepted: %0d required 200", accepted);
    end
    wait_quiet();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: %0d bytes left required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
